// File: rtl/pixsel_pipe.sv
// pixsel_pipe: two-stage pipelined pixel output selector.
// Chooses per-frame display modes from RGB/Y/U/V with saturating skin tints.
// It also counts filtered skin pixels per frame.
// Optional macro SKIN_FILTER_EN enables a WIN-pixel majority filter on in_skin.
// Without the macro, skin_f is in_skin delayed one stage.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid, in_sof           pixel qualifier, first pixel of frame
//   in_r/g/b, in_y/u/v         colour channels (DW bits each)
//   in_skin, in_ctrl, mode_req raw skin flag, sideband, requested mode
//   out_valid, out_sof         pixel qualifier / frame start, 2-cycle latency
//   out_r/g/b, out_ctrl        selected pixel, delayed sideband
//   mode_active                mode latched at the last accepted sof
//   skin_count(_valid)         skin pixels of last complete frame, update pulse
module pixsel_pipe #(
  parameter int unsigned DW     = 8,
  parameter int unsigned CW     = 3,
  parameter int unsigned UP_OFS = 64,
  parameter int unsigned DN_OFS = 32,
  parameter int unsigned WIN    = 5,
  parameter int unsigned CNT_W  = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [DW-1:0]    in_r,
  input  logic [DW-1:0]    in_g,
  input  logic [DW-1:0]    in_b,
  input  logic [DW-1:0]    in_y,
  input  logic [DW-1:0]    in_u,
  input  logic [DW-1:0]    in_v,
  input  logic             in_skin,
  input  logic [CW-1:0]    in_ctrl,
  input  logic [3:0]       mode_req,
  output logic             out_valid,
  output logic             out_sof,
  output logic [DW-1:0]    out_r,
  output logic [DW-1:0]    out_g,
  output logic [DW-1:0]    out_b,
  output logic [CW-1:0]    out_ctrl,
  output logic [3:0]       mode_active,
  output logic [CNT_W-1:0] skin_count,
  output logic             skin_count_valid
);

  localparam int unsigned XW = DW + 1;

  // Saturating boost / cut, evaluated one bit wider than the channel
  function automatic logic [DW-1:0] sat_hi(input logic [DW-1:0] x);
    logic [XW-1:0] s;
    s = {1'b0, x} + XW'(UP_OFS);
    return s[DW] ? {DW{1'b1}} : s[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] sat_lo(input logic [DW-1:0] x);
    logic [XW-1:0] d;
    d = {1'b0, x} - XW'(DN_OFS);
    return d[DW] ? {DW{1'b0}} : d[DW-1:0];
  endfunction

  logic          acc_sof_c;
  logic          s1_valid, s1_sof;
  logic [DW-1:0] s1_r, s1_g, s1_b, s1_y, s1_u, s1_v;
  logic [CW-1:0] s1_ctrl;
  logic          skin_f_c;

  assign acc_sof_c = in_valid & in_sof;

  // Stage 1: capture pixel and latch the frame mode on an accepted sof
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_sof      <= 1'b0;
      s1_r        <= '0;
      s1_g        <= '0;
      s1_b        <= '0;
      s1_y        <= '0;
      s1_u        <= '0;
      s1_v        <= '0;
      s1_ctrl     <= '0;
      mode_active <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_sof   <= acc_sof_c;
      s1_ctrl  <= in_ctrl;
      if (in_valid) begin
        s1_r <= in_r;
        s1_g <= in_g;
        s1_b <= in_b;
        s1_y <= in_y;
        s1_u <= in_u;
        s1_v <= in_v;
      end
      if (acc_sof_c) mode_active <= mode_req;
    end
  end

`ifdef SKIN_FILTER_EN
  localparam int unsigned THR = (WIN + 1) / 2;
  localparam int unsigned PW  = $clog2(WIN + 1);

  logic [WIN-1:0] win_q;
  logic [PW-1:0]  ones_c;

  // Window restarts at frame start so earlier frames never leak in
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q <= '0;
    end else if (in_valid) begin
      win_q <= acc_sof_c ? WIN'(in_skin) : WIN'({win_q, in_skin});
    end
  end

  // Majority vote over the window
  always_comb begin
    ones_c = '0;
    for (int i = 0; i < WIN; i++) ones_c = ones_c + PW'(win_q[i]);
    skin_f_c = (ones_c >= PW'(THR));
  end
`else
  logic s1_skin;

  always_ff @(posedge clk) begin
    if (rst) s1_skin <= 1'b0;
    else     s1_skin <= in_skin;
  end

  assign skin_f_c = s1_skin;
`endif

  logic [DW-1:0] sel_r, sel_g, sel_b;

  // Stage 2 select
  always_comb begin
    sel_r = s1_r;
    sel_g = s1_g;
    sel_b = s1_b;
    case (mode_active)
      4'd1: begin sel_r = s1_y; sel_g = s1_y; sel_b = s1_y; end
      4'd2: begin sel_r = s1_u; sel_g = s1_u; sel_b = s1_u; end
      4'd3: begin sel_r = s1_v; sel_g = s1_v; sel_b = s1_v; end
      4'd4: if (skin_f_c) begin sel_r = s1_y; sel_g = s1_y; sel_b = s1_y; end
      4'd5: if (skin_f_c) begin
        sel_r = sat_lo(s1_r); sel_g = sat_hi(s1_g); sel_b = sat_lo(s1_b);
      end
      4'd6: if (skin_f_c) begin
        sel_r = sat_hi(s1_r); sel_g = sat_lo(s1_g); sel_b = sat_lo(s1_b);
      end
      4'd7: if (skin_f_c) begin
        sel_r = sat_lo(s1_r); sel_g = sat_lo(s1_g); sel_b = sat_hi(s1_b);
      end
      4'd8: if (!skin_f_c) begin sel_r = '0; sel_g = '0; sel_b = '0; end
      default: ;
    endcase
  end

  logic             first_frame;
  logic [CNT_W-1:0] run_q;

  // Stage 2 output registers and per-frame skin counter
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid        <= 1'b0;
      out_sof          <= 1'b0;
      out_r            <= '0;
      out_g            <= '0;
      out_b            <= '0;
      out_ctrl         <= '0;
      skin_count       <= '0;
      skin_count_valid <= 1'b0;
      run_q            <= '0;
      first_frame      <= 1'b1;
    end else begin
      out_valid        <= s1_valid;
      out_sof          <= s1_sof;
      out_ctrl         <= s1_ctrl;
      skin_count_valid <= 1'b0;
      if (s1_valid) begin
        out_r <= sel_r;
        out_g <= sel_g;
        out_b <= sel_b;
        if (s1_sof) begin
          // Report the finished frame, then restart with the sof pixel
          if (!first_frame) begin
            skin_count       <= run_q;
            skin_count_valid <= 1'b1;
          end
          first_frame <= 1'b0;
          run_q       <= CNT_W'(skin_f_c);
        end else if (!first_frame && skin_f_c && (run_q != {CNT_W{1'b1}})) begin
          run_q <= run_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pixsel_pipe.sv
module tb_pixsel_pipe;

  localparam int unsigned WIN = 5;

  logic        clk, rst;
  logic        in_valid, in_sof, in_skin;
  logic [7:0]  in_r, in_g, in_b, in_y, in_u, in_v;
  logic [2:0]  in_ctrl;
  logic [3:0]  mode_req;
  logic        out_valid, out_sof, skin_count_valid;
  logic [7:0]  out_r, out_g, out_b;
  logic [2:0]  out_ctrl;
  logic [3:0]  mode_active;
  logic [19:0] skin_count;

  pixsel_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_y(in_y), .in_u(in_u), .in_v(in_v),
    .in_skin(in_skin), .in_ctrl(in_ctrl), .mode_req(mode_req),
    .out_valid(out_valid), .out_sof(out_sof), .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_ctrl(out_ctrl), .mode_active(mode_active), .skin_count(skin_count),
    .skin_count_valid(skin_count_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic valid, sof;
    logic [7:0] r, g, b, y, u, v;
    logic skin;
    logic [2:0] ctrl;
    logic [3:0] mode;
    logic hx_rgb;
    logic [7:0] hr, hg, hb;
    logic hx_cnt, hp;
    logic [19:0] hc;
  } vec_t;

  typedef struct {
    logic v, sof;
    logic [7:0] r, g, b;
    logic [2:0] ctrl;
    logic [3:0] mode;
    logic pulse;
    logic [19:0] cnt;
    logic hx_rgb;
    logic [7:0] hr, hg, hb;
    logic hx_cnt, hp;
    logic [19:0] hc;
  } exp_t;

  int n_chk = 0;
  int n_pass = 0;
  exp_t pipe[$];

  // Reference model state: frame-level view of the selector
  int m_mode, m_run, m_cnt, m_r, m_g, m_b;
  bit m_first;
  bit m_win[$];

`ifdef SKIN_FILTER_EN
  localparam bit RAW = 1'b0;
`else
  localparam bit RAW = 1'b1;
`endif

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic int hi(input int x);
    return (x + 64 > 255) ? 255 : x + 64;
  endfunction

  function automatic int lo(input int x);
    return (x < 32) ? 0 : x - 32;
  endfunction

  function automatic vec_t mk(input logic valid, input logic sof, input logic [7:0] r,
                              input logic [7:0] g, input logic [7:0] b, input logic skin,
                              input logic [3:0] mode);
    vec_t t;
    t.valid = valid; t.sof = sof; t.r = r; t.g = g; t.b = b; t.skin = skin; t.mode = mode;
    t.y = r ^ 8'h5a; t.u = g + 8'd3; t.v = b ^ 8'hc3;
    t.ctrl = r[2:0] ^ g[2:0];
    t.hx_rgb = 1'b0; t.hr = '0; t.hg = '0; t.hb = '0;
    t.hx_cnt = 1'b0; t.hp = 1'b0; t.hc = '0;
    return t;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.v = 0; e.sof = 0; e.r = 0; e.g = 0; e.b = 0; e.ctrl = 0; e.mode = 0;
    e.pulse = 0; e.cnt = 0; e.hx_rgb = 0; e.hr = 0; e.hg = 0; e.hb = 0;
    e.hx_cnt = 0; e.hp = 0; e.hc = 0;
    return e;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_cnt = 0; m_r = 0; m_g = 0; m_b = 0;
    m_first = 1'b1;
    m_win.delete();
  endtask

  task automatic model(input vec_t vi, output exp_t e);
    bit acc, sf;
    int ones;
    int r, g, b;
    bit pulse;
    acc = vi.valid && vi.sof;
    if (acc) m_mode = vi.mode;
`ifdef SKIN_FILTER_EN
    if (vi.valid) begin
      if (acc) m_win.delete();
      m_win.push_back(vi.skin);
      if (m_win.size() > WIN) void'(m_win.pop_front());
    end
    ones = 0;
    foreach (m_win[i]) ones += m_win[i];
    sf = (ones >= (WIN + 1) / 2);
`else
    ones = 0;
    sf = vi.skin;
`endif
    pulse = 1'b0;
    if (vi.valid) begin
      r = vi.r; g = vi.g; b = vi.b;
      case (m_mode)
        1: begin r = vi.y; g = vi.y; b = vi.y; end
        2: begin r = vi.u; g = vi.u; b = vi.u; end
        3: begin r = vi.v; g = vi.v; b = vi.v; end
        4: if (sf) begin r = vi.y; g = vi.y; b = vi.y; end
        5: if (sf) begin r = lo(vi.r); g = hi(vi.g); b = lo(vi.b); end
        6: if (sf) begin r = hi(vi.r); g = lo(vi.g); b = lo(vi.b); end
        7: if (sf) begin r = lo(vi.r); g = lo(vi.g); b = hi(vi.b); end
        8: if (!sf) begin r = 0; g = 0; b = 0; end
        default: ;
      endcase
      m_r = r; m_g = g; m_b = b;
      if (acc) begin
        if (!m_first) begin pulse = 1'b1; m_cnt = m_run; end
        m_first = 1'b0;
        m_run = sf;
      end else if (!m_first && sf && m_run < (1 << 20) - 1) begin
        m_run++;
      end
    end
    e.v = vi.valid; e.sof = acc; e.ctrl = vi.ctrl; e.mode = 4'(m_mode);
    e.r = 8'(m_r); e.g = 8'(m_g); e.b = 8'(m_b);
    e.pulse = pulse; e.cnt = 20'(m_cnt);
    e.hx_rgb = vi.hx_rgb; e.hr = vi.hr; e.hg = vi.hg; e.hb = vi.hb;
    e.hx_cnt = vi.hx_cnt; e.hp = vi.hp; e.hc = vi.hc;
  endtask

  task automatic drive(input vec_t vi);
    in_valid = vi.valid; in_sof = vi.sof; in_r = vi.r; in_g = vi.g; in_b = vi.b;
    in_y = vi.y; in_u = vi.u; in_v = vi.v; in_skin = vi.skin; in_ctrl = vi.ctrl;
    mode_req = vi.mode;
  endtask

  // One cycle: check outputs for the pixel driven two cycles ago, drive the next
  task automatic step(input vec_t vi);
    exp_t e0, e1, en;
    @(negedge clk);
    if (pipe.size() == 2) begin
      e0 = pipe[0];
      e1 = pipe[1];
      chk("out_valid", out_valid, e0.v);
      chk("out_sof", out_sof, e0.sof);
      chk("out_ctrl", out_ctrl, e0.ctrl);
      chk("out_r", out_r, e0.r);
      chk("out_g", out_g, e0.g);
      chk("out_b", out_b, e0.b);
      chk("mode_active", mode_active, e1.mode);
      chk("skin_count_valid", skin_count_valid, e0.pulse);
      chk("skin_count", skin_count, e0.cnt);
      if (e0.hx_rgb) begin
        chk("hand_r", out_r, e0.hr);
        chk("hand_g", out_g, e0.hg);
        chk("hand_b", out_b, e0.hb);
      end
      if (e0.hx_cnt) begin
        chk("hand_pulse", skin_count_valid, e0.hp);
        chk("hand_count", skin_count, e0.hc);
      end
      void'(pipe.pop_front());
    end
    drive(vi);
    model(vi, en);
    pipe.push_back(en);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_sof", out_sof, 0);
    chk("rst_rgb", {out_r, out_g, out_b}, 0);
    chk("rst_ctrl", out_ctrl, 0);
    chk("rst_mode", mode_active, 0);
    chk("rst_count", skin_count, 0);
    chk("rst_pulse", skin_count_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    pipe.delete();
    pipe.push_back(zero_exp());
    pipe.push_back(zero_exp());
  endtask

  function automatic vec_t hrgb(input vec_t t, input logic en, input logic [7:0] r,
                                input logic [7:0] g, input logic [7:0] b);
    vec_t o;
    o = t; o.hx_rgb = en; o.hr = r; o.hg = g; o.hb = b;
    return o;
  endfunction

  function automatic vec_t hcnt(input vec_t t, input logic p, input logic [19:0] c);
    vec_t o;
    o = t; o.hx_cnt = 1'b1; o.hp = p; o.hc = c;
    return o;
  endfunction

  vec_t tbl[8];
  bit pat[7];
  bit sfe[7];
  vec_t rv;

  initial begin
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0));
    model_reset();
    do_reset();

    // Directed table: tints, mid-frame mode_req, gaps, sof without valid
    tbl[0] = hrgb(mk(1, 1, 200, 220, 10, 1, 5), RAW, 168, 255, 0);
    tbl[1] = hrgb(mk(1, 0, 200, 220, 10, 1, 0), RAW, 168, 255, 0);
    tbl[2] = hrgb(mk(1, 1, 20, 40, 100, 1, 6), RAW, 84, 8, 68);
    tbl[3] = hrgb(mk(1, 0, 20, 40, 100, 0, 6), 1'b1, 20, 40, 100);
    tbl[4] = hrgb(mk(1, 0, 20, 40, 100, 1, 3), RAW, 84, 8, 68);
    tbl[5] = hrgb(mk(0, 1, 1, 2, 3, 1, 1), RAW, 84, 8, 68);
    tbl[6] = hrgb(mk(1, 0, 20, 40, 100, 1, 0), RAW, 84, 8, 68);
    tbl[7] = hrgb(mk(1, 0, 9, 9, 9, 0, 0), RAW, 9, 9, 9);
    foreach (tbl[i]) step(tbl[i]);
    chk("mode_hold", mode_active, 6);

    // Mode 8 against the skin pattern, raw or filtered
    pat = '{1, 1, 0, 1, 0, 0, 0};
`ifdef SKIN_FILTER_EN
    sfe = '{0, 0, 0, 1, 1, 0, 0};
`else
    sfe = pat;
`endif
    for (int i = 0; i < 7; i++)
      step(hrgb(mk(1, i == 0, 10, 20, 30, pat[i], 8), 1'b1,
                sfe[i] ? 8'd10 : 8'd0, sfe[i] ? 8'd20 : 8'd0, sfe[i] ? 8'd30 : 8'd0));

    // Skin counter: first frame silent, frame A of 10 pixels with 6 filtered skin
    do_reset();
    step(hcnt(mk(1, 1, 50, 60, 70, 1, 0), 0, 0));
    for (int i = 0; i < 3; i++) step(mk(1, 0, 50, 60, 70, 1, 0));
    for (int i = 0; i < 10; i++) begin
      step(mk(1, i == 0, 8'(i), 8'(3 * i), 8'(7 * i), i < 6, 4));
      if (i == 4) step(mk(0, 0, 1, 1, 1, 0, 0));
    end
    step(hcnt(mk(1, 1, 5, 6, 7, 0, 0), 1, 6));
    step(hcnt(mk(1, 0, 5, 6, 7, 1, 0), 0, 6));
    step(mk(0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0));

    // Reset mid-frame: mode back to 0, no report at the next sof
    step(mk(1, 1, 90, 90, 90, 1, 7));
    step(mk(1, 0, 90, 90, 90, 1, 7));
    do_reset();
    step(mk(1, 0, 90, 90, 90, 1, 5));
    step(hcnt(mk(1, 1, 90, 90, 90, 1, 6), 0, 0));
    for (int i = 0; i < 4; i++) step(mk(1, 0, 90, 90, 90, 1, 6));
    step(mk(1, 1, 90, 90, 90, 1, 2));

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      rv = mk($urandom_range(3, 0) != 0, $urandom_range(19, 0) == 0,
              8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom));
      rv.y = 8'($urandom); rv.u = 8'($urandom); rv.v = 8'($urandom);
      rv.ctrl = 3'($urandom);
      step(rv);
      if (i == 300) do_reset();
    end
    step(mk(0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
